lsu_ctrl: RTL and testbench

Parametrised, registered load-store unit between the core's memory stage and the data memory bus. It generalises data width (32 or 64 bit), adds an explicit request/acknowledge state machine with registered memory-side outputs, and adds misalignment trapping and a bus-timeout error. The core stalls for the duration of every access and sees sign/zero-extended read data when the stall drops.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 30 +++
 rtl/lsu_ctrl.sv | 134 +++++++++++++
 tb/tb_lsu_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit: access size codes, FSM states
// and the size-to-byte-count helper used for alignment and lane masks.
package lsu_pkg;

  typedef enum logic [2:0] {
    DATA_SIZE_BYTE   = 3'd0,
    DATA_SIZE_HALF   = 3'd1,
    DATA_SIZE_WORD   = 3'd2,
    DATA_SIZE_DOUBLE = 3'd3,
    DATA_SIZE_U_BYTE = 3'd4,
    DATA_SIZE_U_HALF = 3'd5,
    DATA_SIZE_U_WORD = 3'd6
  } data_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  localparam int SIZE_W = 3;

  // Zero means the size code is not usable on this bus width.
  function automatic logic [3:0] size_bytes(input logic [SIZE_W-1:0] size, input int data_width);
    case (size)
      DATA_SIZE_BYTE, DATA_SIZE_U_BYTE: return 4'd1;
      DATA_SIZE_HALF, DATA_SIZE_U_HALF: return 4'd2;
      DATA_SIZE_WORD:                   return 4'd4;
      DATA_SIZE_U_WORD:                 return (data_width == 64) ? 4'd4 : 4'd0;
      DATA_SIZE_DOUBLE:                 return (data_width == 64) ? 4'd8 : 4'd0;
      default:                          return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed lane from a full bus word and sign- or zero-extends
// it to the bus width according to the access size code.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]           bus_word,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] offset,
  input  logic [SIZE_W-1:0]               size,
  output logic [DATA_WIDTH-1:0]           load_value
);

  logic [DATA_WIDTH-1:0] shifted;

  always_comb begin
    shifted    = bus_word >> {offset, 3'b000};
    load_value = shifted;
    case (size)
      DATA_SIZE_BYTE:   load_value = DATA_WIDTH'($signed(shifted[7:0]));
      DATA_SIZE_U_BYTE: load_value = DATA_WIDTH'(shifted[7:0]);
      DATA_SIZE_HALF:   load_value = DATA_WIDTH'($signed(shifted[15:0]));
      DATA_SIZE_U_HALF: load_value = DATA_WIDTH'(shifted[15:0]);
      DATA_SIZE_WORD:   load_value = DATA_WIDTH'($signed(shifted[31:0]));
      DATA_SIZE_U_WORD: load_value = DATA_WIDTH'(shifted[31:0]);
      default:          load_value = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Registered load-store unit: stalls the core for each access, drives the
// memory bus from registers while BUSY, traps misalignment and bus timeouts.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   core_address,
  input  logic [DATA_WIDTH-1:0]   core_write_data,
  input  logic                    core_require,
  input  logic                    core_write_enable,
  input  logic [SIZE_W-1:0]       core_size,
  output logic                    core_stall_signal,
  output logic [DATA_WIDTH-1:0]   core_read_data,
  output logic                    core_misaligned,
  output logic                    core_bus_error,
  output logic                    memory_require,
  output logic                    memory_write_enable,
  output logic [DATA_WIDTH/8-1:0] memory_byte_enable_map,
  output logic [ADDR_WIDTH-1:0]   memory_address,
  output logic [DATA_WIDTH-1:0]   memory_write_data,
  input  logic [DATA_WIDTH-1:0]   memory_read_data,
  input  logic                    memory_end_signal
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e        state, state_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [SIZE_W-1:0] size_q;
  logic [OFF_W-1:0]  offset_q;
  logic [3:0]        access_bytes;
  logic [OFF_W-1:0]  offset, align_mask;
  logic              aligned, accept, timed_out;
  logic [8:0]        lane_ones;
  logic [BYTES-1:0]  byte_enable;
  logic [DATA_WIDTH-1:0] write_rep, load_value;

  always_comb begin
    access_bytes = size_bytes(core_size, DATA_WIDTH);
    offset       = core_address[OFF_W-1:0];
    align_mask   = OFF_W'(access_bytes - 4'd1);
    aligned      = (access_bytes != 4'd0) && ((offset & align_mask) == '0);
    lane_ones    = (9'd1 << access_bytes) - 9'd1;
    byte_enable  = BYTES'(lane_ones) << offset;
    case (access_bytes)
      4'd1:    write_rep = {BYTES{core_write_data[7:0]}};
      4'd2:    write_rep = {(BYTES/2){core_write_data[15:0]}};
      4'd4:    write_rep = {(BYTES/4){core_write_data[31:0]}};
      default: write_rep = core_write_data;
    endcase
  end

  assign accept    = (state == ST_IDLE) && core_require && aligned;
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Gated by reset_n so the core sees all-zero outputs while reset is held.
  assign core_stall_signal = reset_n && (accept || (state == ST_BUSY));
  assign core_misaligned   = reset_n && (state == ST_IDLE) && core_require && !aligned;
  assign memory_require    = (state == ST_BUSY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: if (memory_end_signal || timed_out) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
    .bus_word   (memory_read_data),
    .offset     (offset_q),
    .size       (size_q),
    .load_value (load_value)
  );

  // End takes priority over timeout when both land in the same BUSY cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt               <= '0;
      size_q                 <= '0;
      offset_q               <= '0;
      core_read_data         <= '0;
      core_bus_error         <= 1'b0;
      memory_write_enable    <= 1'b0;
      memory_byte_enable_map <= '0;
      memory_address         <= '0;
      memory_write_data      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            wait_cnt               <= '0;
            size_q                 <= core_size;
            offset_q               <= offset;
            memory_write_enable    <= core_write_enable;
            memory_byte_enable_map <= byte_enable;
            memory_address         <= {core_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            memory_write_data      <= write_rep;
          end
        end
        ST_BUSY: begin
          if (memory_end_signal) begin
            if (!memory_write_enable) core_read_data <= load_value;
          end else if (timed_out) begin
            core_bus_error <= 1'b1;
            core_read_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          core_bus_error <= 1'b0;
          wait_cnt       <= '0;
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: a 32-bit and a 64-bit instance share the
// core inputs and are compared against an arithmetic model of the access rules.
module tb_lsu_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] core_address;
  logic [63:0] core_write_data;
  logic        core_write_enable;
  logic [2:0]  core_size;
  logic        req32, req64, end32, end64;
  logic [63:0] memory_read_data;

  logic        stall32, mis32, berr32, mreq32, mwe32;
  logic [31:0] rd32, maddr32, mwdata32;
  logic [3:0]  be32;
  logic        stall64, mis64, berr64, mreq64, mwe64;
  logic [63:0] rd64, mwdata64;
  logic [31:0] maddr64;
  logic [7:0]  be64;

  logic        sel64;
  logic        obs_stall, obs_mis, obs_berr, obs_mreq, obs_mwe;
  logic [63:0] obs_rd, obs_mwdata;
  logic [31:0] obs_maddr;
  logic [7:0]  obs_be;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_rd32 = '0;
  logic [63:0] last_rd64 = '0;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut32 (
    .clk                    (clk),
    .reset_n                (reset_n),
    .core_address           (core_address),
    .core_write_data        (core_write_data[31:0]),
    .core_require           (req32),
    .core_write_enable      (core_write_enable),
    .core_size              (core_size),
    .core_stall_signal      (stall32),
    .core_read_data         (rd32),
    .core_misaligned        (mis32),
    .core_bus_error         (berr32),
    .memory_require         (mreq32),
    .memory_write_enable    (mwe32),
    .memory_byte_enable_map (be32),
    .memory_address         (maddr32),
    .memory_write_data      (mwdata32),
    .memory_read_data       (memory_read_data[31:0]),
    .memory_end_signal      (end32)
  );

  lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut64 (
    .clk                    (clk),
    .reset_n                (reset_n),
    .core_address           (core_address),
    .core_write_data        (core_write_data),
    .core_require           (req64),
    .core_write_enable      (core_write_enable),
    .core_size              (core_size),
    .core_stall_signal      (stall64),
    .core_read_data         (rd64),
    .core_misaligned        (mis64),
    .core_bus_error         (berr64),
    .memory_require         (mreq64),
    .memory_write_enable    (mwe64),
    .memory_byte_enable_map (be64),
    .memory_address         (maddr64),
    .memory_write_data      (mwdata64),
    .memory_read_data       (memory_read_data),
    .memory_end_signal      (end64)
  );

  assign obs_stall  = sel64 ? stall64 : stall32;
  assign obs_mis    = sel64 ? mis64   : mis32;
  assign obs_berr   = sel64 ? berr64  : berr32;
  assign obs_mreq   = sel64 ? mreq64  : mreq32;
  assign obs_mwe    = sel64 ? mwe64   : mwe32;
  assign obs_rd     = sel64 ? rd64    : {32'd0, rd32};
  assign obs_mwdata = sel64 ? mwdata64 : {32'd0, mwdata32};
  assign obs_maddr  = sel64 ? maddr64 : maddr32;
  assign obs_be     = sel64 ? be64    : {4'd0, be32};

  // Access width in bytes by size code; zero marks a size illegal on this bus.
  function automatic int model_bytes(input logic [2:0] size, input int dw);
    case (size)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      3'd3:       return (dw == 64) ? 8 : 0;
      3'd6:       return (dw == 64) ? 4 : 0;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] size, input int dw);
    int nb;
    int off;
    logic [63:0] v, keep;
    nb   = model_bytes(size, dw) * 8;
    off  = int'(addr % 32'(dw / 8));
    v    = rdata >> (8 * off);
    keep = (nb == 64) ? '1 : ((64'd1 << nb) - 64'd1);
    v    = v & keep;
    if (size <= 3'd3 && nb < 64 && v[nb-1]) v = v | ~keep;
    if (dw == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wdata, input int nb, input int dw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < dw / 8; i++) r[8*i +: 8] = wdata[8*(i % nb) +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic setReq(input bit use64, input logic v);
    if (use64) req64 = v;
    else       req32 = v;
  endtask

  task automatic setEnd(input bit use64, input logic v);
    if (use64) end64 = v;
    else       end32 = v;
  endtask

  // One complete access; latency > TMO means the memory never answers.
  task automatic applyStimulus(input bit use64, input logic [31:0] addr, input logic [63:0] wdata,
                               input logic we, input logic [2:0] size, input int latency,
                               input logic [63:0] rdata);
    int dw, nb, off, n_busy;
    bit timeout_exp;
    logic [63:0] exp_rd;
    dw          = use64 ? 64 : 32;
    nb          = model_bytes(size, dw);
    off         = int'(addr % 32'(dw / 8));
    timeout_exp = (latency > TMO);
    n_busy      = timeout_exp ? TMO + 1 : latency + 1;

    @(negedge clk);
    sel64             = use64;
    core_address      = addr;
    core_write_data   = wdata;
    core_write_enable = we;
    core_size         = size;
    setReq(use64, 1'b1);
    #1;
    if (nb == 0 || (addr % 32'(nb)) != 0) begin
      checkOutput("misaligned_flag", 64'(obs_mis), 64'd1);
      checkOutput("misaligned_stall", 64'(obs_stall), 64'd0);
      @(negedge clk);
      setReq(use64, 1'b0);
      #1;
      checkOutput("misaligned_no_bus", 64'(obs_mreq), 64'd0);
      checkOutput("misaligned_pulse_ends", 64'(obs_mis), 64'd0);
      return;
    end
    checkOutput("accept_stall", 64'(obs_stall), 64'd1);
    checkOutput("accept_no_trap", 64'(obs_mis), 64'd0);

    for (int c = 0; c < n_busy; c++) begin
      @(negedge clk);
      #1;
      checkOutput("busy_mem_require", 64'(obs_mreq), 64'd1);
      checkOutput("busy_stall", 64'(obs_stall), 64'd1);
      if (c == 0 || c == n_busy - 1) begin
        checkOutput("busy_byte_enable", 64'(obs_be),
                    ((64'd1 << nb) - 64'd1) << off);
        checkOutput("busy_address", 64'(obs_maddr), 64'(addr) - 64'(off));
        checkOutput("busy_write_data", obs_mwdata, model_wdata(wdata, nb, dw));
        checkOutput("busy_write_enable", 64'(obs_mwe), 64'(we));
      end
      if (!timeout_exp && c == latency) begin
        memory_read_data = rdata;
        setEnd(use64, 1'b1);
      end else begin
        memory_read_data = {$urandom, $urandom};
      end
      if ($urandom_range(0, 3) == 0) setReq(use64, 1'b0);
    end

    @(negedge clk);
    setEnd(use64, 1'b0);
    #1;
    exp_rd = use64 ? last_rd64 : last_rd32;
    if (timeout_exp) exp_rd = '0;
    else if (!we)    exp_rd = model_load(rdata, addr, size, dw);
    if (use64) last_rd64 = exp_rd;
    else       last_rd32 = exp_rd;
    checkOutput("done_stall", 64'(obs_stall), 64'd0);
    checkOutput("done_mem_require", 64'(obs_mreq), 64'd0);
    checkOutput("done_bus_error", 64'(obs_berr), 64'(timeout_exp));
    checkOutput("done_read_data", obs_rd, exp_rd);
    setReq(use64, 1'b0);
    if (timeout_exp) begin
      @(negedge clk);
      #1;
      checkOutput("after_done_bus_error", 64'(obs_berr), 64'd0);
      checkOutput("after_done_idle", 64'(obs_mreq), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;

    reset_n           = 1'b0;
    sel64             = 1'b0;
    core_address      = '0;
    core_write_data   = '0;
    core_write_enable = 1'b0;
    core_size         = '0;
    req32 = 1'b0; req64 = 1'b0; end32 = 1'b0; end64 = 1'b0;
    memory_read_data  = '0;
    #1;
    checkOutput("reset_stall", 64'(stall32), 64'd0);
    checkOutput("reset_read_data", 64'(rd32), 64'd0);
    checkOutput("reset_misaligned", 64'(mis32), 64'd0);
    checkOutput("reset_bus_error", 64'(berr32), 64'd0);
    checkOutput("reset_mem_require", 64'(mreq32), 64'd0);
    checkOutput("reset_write_enable", 64'(mwe32), 64'd0);
    checkOutput("reset_byte_enable", 64'(be32), 64'd0);
    checkOutput("reset_address", 64'(maddr32), 64'd0);
    checkOutput("reset_write_data", 64'(mwdata32), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases on the 32-bit bus.
    applyStimulus(1'b0, 32'h104, 64'd0, 1'b0, 3'd2, 2, 64'h8000_00FF);
    checkOutput("lw_result", 64'(rd32), 64'h8000_00FF);
    applyStimulus(1'b0, 32'h103, 64'd0, 1'b0, 3'd0, 1, 64'h8012_3456);
    checkOutput("lb_result", 64'(rd32), 64'hFFFF_FF80);
    applyStimulus(1'b0, 32'h103, 64'd0, 1'b0, 3'd4, 0, 64'h8012_3456);
    checkOutput("lbu_result", 64'(rd32), 64'h0000_0080);
    applyStimulus(1'b0, 32'h102, 64'h1234, 1'b1, 3'd1, 1, 64'hDEAD_BEEF);
    checkOutput("sh_keeps_read_data", 64'(rd32), 64'h0000_0080);
    applyStimulus(1'b0, 32'h102, 64'd0, 1'b0, 3'd2, 0, 64'd0);
    applyStimulus(1'b0, 32'h108, 64'd0, 1'b0, 3'd3, 0, 64'd0);
    applyStimulus(1'b0, 32'h200, 64'd0, 1'b0, 3'd2, 100, 64'd0);
    applyStimulus(1'b0, 32'h206, 64'd0, 1'b0, 3'd5, TMO, 64'hABCD_0000);

    // A stray end pulse while idle must not start or complete anything.
    @(negedge clk);
    sel64 = 1'b0;
    memory_read_data = 64'h5555_5555;
    end32 = 1'b1;
    @(negedge clk);
    end32 = 1'b0;
    #1;
    checkOutput("idle_end_ignored_req", 64'(mreq32), 64'd0);
    checkOutput("idle_end_ignored_data", 64'(rd32), last_rd32);

    for (int i = 0; i < 40; i++) begin
      a = $urandom & 32'hFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      sz = 3'($urandom_range(0, 6));
      applyStimulus(1'b0, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz,
                    $urandom_range(0, 3), {$urandom, $urandom});
    end

    // 64-bit bus.
    applyStimulus(1'b1, 32'h08, 64'd0, 1'b0, 3'd3, 1, 64'h0123_4567_89AB_CDEF);
    checkOutput("ld_result", rd64, 64'h0123_4567_89AB_CDEF);
    applyStimulus(1'b1, 32'h0C, 64'd0, 1'b0, 3'd6, 0, 64'hDEAD_BEEF_0000_0000);
    checkOutput("lwu_result", rd64, 64'h0000_0000_DEAD_BEEF);
    applyStimulus(1'b1, 32'h0C, 64'd0, 1'b0, 3'd2, 2, 64'hDEAD_BEEF_0000_0000);
    checkOutput("lw64_result", rd64, 64'hFFFF_FFFF_DEAD_BEEF);
    for (int i = 0; i < 25; i++) begin
      a = $urandom & 32'hFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h7;
      sz = 3'($urandom_range(0, 6));
      applyStimulus(1'b1, a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), sz,
                    $urandom_range(0, 3), {$urandom, $urandom});
    end

    // Reset in the middle of a 64-bit access aborts it asynchronously.
    @(negedge clk);
    sel64 = 1'b1;
    core_address = 32'h08; core_size = 3'd3; core_write_enable = 1'b1;
    core_write_data = 64'hFEED_FACE_CAFE_F00D;
    req64 = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("ld_busy_byte_enable", 64'(be64), 64'hFF);
    checkOutput("ld_busy_mem_require", 64'(mreq64), 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abort_mem_require", 64'(mreq64), 64'd0);
    checkOutput("abort_stall", 64'(stall64), 64'd0);
    checkOutput("abort_byte_enable", 64'(be64), 64'd0);
    checkOutput("abort_address", 64'(maddr64), 64'd0);
    checkOutput("abort_write_data", mwdata64, 64'd0);
    checkOutput("abort_write_enable", 64'(mwe64), 64'd0);
    checkOutput("abort_read_data", rd64, 64'd0);
    checkOutput("abort_bus_error", 64'(berr64), 64'd0);
    checkOutput("abort_misaligned", 64'(mis64), 64'd0);
    req64 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("after_abort_no_completion", 64'(mreq64) | 64'(berr64) | 64'(stall64), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
